// File: rtl/lfsr_byte_pwm_if.sv
// Valid/ready byte stream from the LFSR stage into the PWM block.
// The producer drives data/valid and the PWM block drives ready.
interface lfsr_byte_pwm_if #(
   parameter int W = 8
);
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/lfsr_byte_pwm.sv
// Turns each random byte into the duty of one PWM period.
// A one-entry pending buffer is swapped in only at the period wrap.
module lfsr_byte_pwm #(
   parameter int W   = 8,
   parameter int DIV = 1
) (
   input  logic           clk,
   input  logic           rst,
   lfsr_byte_pwm_if.slave src,
   output logic           pwm_out,
   output logic           period_end,
   output logic           underrun
);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   logic [DW-1:0] div_cnt;
   logic [W-1:0]  pwm_cnt;
   logic [W-1:0]  active_duty;
   logic [W-1:0]  pend;
   logic          pend_valid;
   logic          pend_valid_nxt;
   logic          in_ready_q;
   logic          tick;
   logic          wrap;
   logic          xfer;

   assign src.in_ready = in_ready_q;

   // A transfer on a wrap edge only fills pend; that wrap counts as an underrun.
   always_comb begin
      tick           = (div_cnt == DIV_LAST);
      wrap           = tick && (pwm_cnt == '1);
      xfer           = src.in_valid && in_ready_q;
      pend_valid_nxt = pend_valid;
      if (xfer) begin
         pend_valid_nxt = 1'b1;
      end else if (wrap) begin
         pend_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt     <= '0;
         pwm_cnt     <= '0;
         active_duty <= '0;
         pend        <= '0;
         pend_valid  <= 1'b0;
         in_ready_q  <= 1'b0;
         pwm_out     <= 1'b0;
         period_end  <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + DW'(1);
         if (tick) begin
            pwm_cnt <= pwm_cnt + W'(1);
         end
         if (wrap && pend_valid) begin
            active_duty <= pend;
         end
         if (xfer) begin
            pend <= src.in_data;
         end
         pend_valid <= pend_valid_nxt;
         in_ready_q <= !pend_valid_nxt;
         period_end <= wrap;
         underrun   <= wrap && !pend_valid;
         pwm_out    <= (pwm_cnt < active_duty);
      end
   end
endmodule

// File: tb/tb_lfsr_byte_pwm.sv
// Directed bench: DUT a runs DIV=1, DUT b runs DIV=3 with its own reset.
// Periods are measured between period_end pulses, pwm_out lagging one cycle.
module tb_lfsr_byte_pwm;
   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   logic a_pwm, a_pe, a_ur;
   logic b_pwm, b_pe, b_ur;
   int   n_checks = 0;
   int   n_pass = 0;

   lfsr_byte_pwm_if #(.W(8)) a_if ();
   lfsr_byte_pwm_if #(.W(8)) b_if ();

   lfsr_byte_pwm #(.W(8), .DIV(1)) dut_a (
      .clk        (clk),
      .rst        (rst_a),
      .src        (a_if),
      .pwm_out    (a_pwm),
      .period_end (a_pe),
      .underrun   (a_ur)
   );

   lfsr_byte_pwm #(.W(8), .DIV(3)) dut_b (
      .clk        (clk),
      .rst        (rst_b),
      .src        (b_if),
      .pwm_out    (b_pwm),
      .period_end (b_pe),
      .underrun   (b_ur)
   );

   always #5 clk = ~clk;

   function automatic logic f_pe(bit s);
      return s ? b_pe : a_pe;
   endfunction

   function automatic logic f_pwm(bit s);
      return s ? b_pwm : a_pwm;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic count_to_pe(input bit s, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!f_pe(s) && n < 3000);
   endtask

   // Window: cycle after one period_end through the next period_end.
   task automatic measure(input bit s, input bit clr,
                          output int hi, output int len);
      hi  = 0;
      len = 0;
      do begin
         step();
         if (clr && len == 0) begin
            if (s) b_if.in_valid = 1'b0;
            else   a_if.in_valid = 1'b0;
         end
         len++;
         hi += int'(f_pwm(s));
      end while (!f_pe(s) && len < 3000);
   endtask

   task automatic test_reset();
      a_if.in_valid = 1'b1;
      a_if.in_data  = 8'hAA;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if ({a_pwm, a_if.in_ready, a_pe, a_ur} !== 4'b0000)
            $display("FAIL reset_outs[%0d]: got %b want 0000", i,
                     {a_pwm, a_if.in_ready, a_pe, a_ur});
         else n_pass++;
      end
      rst_a = 1'b0;
      a_if.in_valid = 1'b0;
      step();
      n_checks++;
      if (a_if.in_ready !== 1'b1)
         $display("FAIL reset_release_ready: got %b want 1", a_if.in_ready);
      else n_pass++;
   endtask

   task automatic test_duty64();
      int n, hi, len;
      a_if.in_data  = 8'd64;
      a_if.in_valid = 1'b1;
      step();
      a_if.in_valid = 1'b0;
      n_checks++;
      if (a_if.in_ready !== 1'b0)
         $display("FAIL d64_ready_drop: got %b want 0", a_if.in_ready);
      else n_pass++;
      count_to_pe(1'b0, n);
      n_checks++;
      if (n !== 254) $display("FAIL d64_first_wrap: got %0d want 254", n);
      else n_pass++;
      n_checks++;
      if ({a_ur, a_if.in_ready} !== 2'b01)
         $display("FAIL d64_load: ur/ready got %b want 01", {a_ur, a_if.in_ready});
      else n_pass++;
      a_if.in_data  = 8'd0;
      a_if.in_valid = 1'b1;
      measure(1'b0, 1'b1, hi, len);
      n_checks++;
      if (hi !== 64 || len !== 256)
         $display("FAIL d64_period: hi %0d len %0d want 64 256", hi, len);
      else n_pass++;
   endtask

   task automatic test_extremes();
      int hi, len;
      n_checks++;
      if (a_ur !== 1'b0) $display("FAIL ext_load0_ur: got %b want 0", a_ur);
      else n_pass++;
      a_if.in_data  = 8'd255;
      a_if.in_valid = 1'b1;
      measure(1'b0, 1'b1, hi, len);
      n_checks++;
      if (hi !== 0 || len !== 256)
         $display("FAIL ext_duty0: hi %0d len %0d want 0 256", hi, len);
      else n_pass++;
      measure(1'b0, 1'b0, hi, len);
      n_checks++;
      if (hi !== 255 || len !== 256)
         $display("FAIL ext_duty255: hi %0d len %0d want 255 256", hi, len);
      else n_pass++;
      n_checks++;
      if (a_ur !== 1'b1) $display("FAIL ext_underrun: got %b want 1", a_ur);
      else n_pass++;
      step();
      n_checks++;
      if (a_ur !== 1'b0) $display("FAIL ext_ur_width: got %b want 0", a_ur);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int n, hi, len;
      a_if.in_data  = 8'd10;
      a_if.in_valid = 1'b1;
      step();
      a_if.in_data = 8'd20;
      repeat (5) step();
      n_checks++;
      if (a_if.in_ready !== 1'b0)
         $display("FAIL b2b_backpressure: got %b want 0", a_if.in_ready);
      else n_pass++;
      count_to_pe(1'b0, n);
      n_checks++;
      if (n !== 249 || a_ur !== 1'b0 || a_if.in_ready !== 1'b1)
         $display("FAIL b2b_wrap: n %0d ur %b ready %b want 249 0 1",
                  n, a_ur, a_if.in_ready);
      else n_pass++;
      measure(1'b0, 1'b0, hi, len);
      a_if.in_valid = 1'b0;
      n_checks++;
      if (hi !== 10 || len !== 256 || a_ur !== 1'b0)
         $display("FAIL b2b_duty10: hi %0d len %0d ur %b want 10 256 0",
                  hi, len, a_ur);
      else n_pass++;
   endtask

   task automatic test_collision();
      int hi, len;
      repeat (255) step();
      n_checks++;
      if (a_pe !== 1'b0) $display("FAIL col_pre_pe: got %b want 0", a_pe);
      else n_pass++;
      a_if.in_data  = 8'd30;
      a_if.in_valid = 1'b1;
      step();
      a_if.in_valid = 1'b0;
      n_checks++;
      if ({a_pe, a_ur, a_if.in_ready} !== 3'b110)
         $display("FAIL col_wrap: pe/ur/ready got %b want 110",
                  {a_pe, a_ur, a_if.in_ready});
      else n_pass++;
      measure(1'b0, 1'b0, hi, len);
      n_checks++;
      if (hi !== 20 || len !== 256 || a_ur !== 1'b0)
         $display("FAIL col_held: hi %0d len %0d ur %b want 20 256 0",
                  hi, len, a_ur);
      else n_pass++;
      measure(1'b0, 1'b0, hi, len);
      n_checks++;
      if (hi !== 30 || len !== 256 || a_ur !== 1'b1)
         $display("FAIL col_applied: hi %0d len %0d ur %b want 30 256 1",
                  hi, len, a_ur);
      else n_pass++;
   endtask

   task automatic test_prescale_reset();
      int n, hi, len;
      n_checks++;
      if ({b_pwm, b_if.in_ready, b_pe, b_ur} !== 4'b0000)
         $display("FAIL b_reset_outs: got %b want 0000",
                  {b_pwm, b_if.in_ready, b_pe, b_ur});
      else n_pass++;
      rst_b = 1'b0;
      b_if.in_data  = 8'd4;
      b_if.in_valid = 1'b1;
      step();
      n_checks++;
      if (b_if.in_ready !== 1'b1)
         $display("FAIL b_release_ready: got %b want 1", b_if.in_ready);
      else n_pass++;
      step();
      b_if.in_valid = 1'b0;
      count_to_pe(1'b1, n);
      n_checks++;
      if (n !== 766 || b_ur !== 1'b0)
         $display("FAIL b_first_wrap: n %0d ur %b want 766 0", n, b_ur);
      else n_pass++;
      b_if.in_data  = 8'd40;
      b_if.in_valid = 1'b1;
      measure(1'b1, 1'b1, hi, len);
      n_checks++;
      if (hi !== 12 || len !== 768)
         $display("FAIL b_duty4: hi %0d len %0d want 12 768", hi, len);
      else n_pass++;
      b_if.in_data  = 8'd9;
      b_if.in_valid = 1'b1;
      step();
      b_if.in_valid = 1'b0;
      repeat (98) step();
      n_checks++;
      if ({b_pwm, b_if.in_ready} !== 2'b10)
         $display("FAIL b_pre_reset: pwm/ready got %b want 10",
                  {b_pwm, b_if.in_ready});
      else n_pass++;
      rst_b = 1'b1;
      step();
      n_checks++;
      if ({b_pwm, b_if.in_ready, b_pe, b_ur} !== 4'b0000)
         $display("FAIL b_mid_reset: got %b want 0000",
                  {b_pwm, b_if.in_ready, b_pe, b_ur});
      else n_pass++;
      rst_b = 1'b0;
      step();
      n_checks++;
      if (b_if.in_ready !== 1'b1)
         $display("FAIL b_rerelease_ready: got %b want 1", b_if.in_ready);
      else n_pass++;
      count_to_pe(1'b1, n);
      n_checks++;
      if (n !== 767 || b_ur !== 1'b1)
         $display("FAIL b_restart_wrap: n %0d ur %b want 767 1", n, b_ur);
      else n_pass++;
      measure(1'b1, 1'b0, hi, len);
      n_checks++;
      if (hi !== 0 || len !== 768)
         $display("FAIL b_after_reset: hi %0d len %0d want 0 768", hi, len);
      else n_pass++;
   endtask

   initial begin
      a_if.in_valid = 1'b0;
      a_if.in_data  = '0;
      b_if.in_valid = 1'b0;
      b_if.in_data  = '0;
      test_reset();
      test_duty64();
      test_extremes();
      test_back_to_back();
      test_collision();
      test_prescale_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
